// File: rtl/game2048_input_ctrl.sv
// 2048 input front end: per-button synchronizer and debouncer, press-edge
// detection with up>down>left>right priority, and a move-issue FSM with lockout.
module game2048_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned LOCKOUT_CYCLES  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic [1:0]  game_state,
  output logic [3:0]  direction,
  output logic        busy,
  output logic [15:0] move_count
);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] LO_LAST = LW'(LOCKOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, LOCKOUT, WAIT_RELEASE} state_t;
  state_t state, state_next;

  logic [3:0]    btn_raw, sync1, s, d, d_prev, press, sel, dir_next;
  logic [CW-1:0] db_cnt [4];
  logic [LW-1:0] lock_cnt;
  logic          busy_next, count_inc;

  // bit order matches the one-hot direction code
  assign btn_raw = {btn_right, btn_left, btn_down, btn_up};
  assign press   = d & ~d_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= '0;
      s      <= '0;
      d      <= '0;
      d_prev <= '0;
      for (int unsigned i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync1  <= btn_raw;
      s      <= sync1;
      d_prev <= d;
      for (int unsigned i = 0; i < 4; i++) begin
        if (s[i] == d[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          d[i]      <= s[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel = '0;
    if (press[0])      sel = 4'b0001;
    else if (press[1]) sel = 4'b0010;
    else if (press[2]) sel = 4'b0100;
    else if (press[3]) sel = 4'b1000;
  end

  always_comb begin
    state_next = state;
    dir_next   = '0;
    count_inc  = 1'b0;
    unique case (state)
      IDLE: begin
        if (press != '0) begin
          if (game_state == 2'b00) begin
            state_next = ISSUE;
            dir_next   = sel;
          end else begin
            state_next = WAIT_RELEASE;
          end
        end
      end
      ISSUE: begin
        count_inc  = 1'b1;
        state_next = LOCKOUT;
      end
      LOCKOUT: begin
        if (lock_cnt == LO_LAST) state_next = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (d == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      direction  <= '0;
      busy       <= 1'b0;
      move_count <= '0;
      lock_cnt   <= '0;
    end else begin
      state     <= state_next;
      direction <= dir_next;
      busy      <= busy_next;
      if (count_inc) move_count <= move_count + 1'b1;
      if (state == LOCKOUT) lock_cnt <= lock_cnt + 1'b1;
      else                  lock_cnt <= '0;
    end
  end
endmodule
